fib_sched: RTL and testbench
============================

// Module: fib_sched
// PURPOSE
//  Round-robin scheduler sharing one fib engine (start/i/ready/done_tick/f) among NREQ requesters.
//  Latches one request at a time, launches the engine, captures the result, returns it to the owner.
//  Sits between the requester blocks and the single engine instance; the engine is external.
// PARAMETERS
//  NREQ        4    number of requesters (2..8)
//  IW          5    index width, matches engine i
//  FW          20   result width, matches engine f
//  TMO_CYCLES  64   WAIT watchdog limit; used only with FIB_SCHED_TIMEOUT_EN
// PORTS
//  clk           in   1        clock, rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  req           in   NREQ     level request per requester; hold until gnt bit seen
//  req_i         in   NREQ*IW  per-requester index; slice k = req_i[k*IW +: IW]
//  gnt           out  NREQ     one-hot, 1-cycle pulse: request k accepted, index sampled
//  resp_tick     out  NREQ     one-hot, 1-cycle pulse: result for requester k valid
//  result        out  FW       result; valid only while any resp_tick bit is high
//  err           out  1        with resp_tick: engine timed out, result = 0
//  busy          out  1        high in every state except IDLE
//  fib_start     out  1        engine start, 1-cycle pulse
//  fib_i         out  IW       engine index, held from START until the next grant
//  fib_ready     in   1        engine idle indicator
//  fib_done_tick in   1        engine completion pulse
//  fib_f         in   FW       engine result, sampled on fib_done_tick
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, owner=0, idx/result regs=0; gnt, resp_tick, err, busy, fib_start all 0.
//  States (2-bit encoded):
//   IDLE : if |req && fib_ready -> pick winner, latch owner and req_i slice -> START; else stay.
//   START: gnt[owner]=1, fib_start=1, fib_i=latched index -> WAIT.
//   WAIT : on fib_done_tick -> result_reg<=fib_f -> DONE; else stay.
//   DONE : resp_tick[owner]=1, result=result_reg, err=err_reg; ptr<=(owner+1)%NREQ -> IDLE.
//  Arbitration: first requester with req high, scanning ptr, ptr+1, ... wrapping modulo NREQ.
//   ptr updates only in DONE, so a served requester has the lowest priority next round.
//  All outputs decode from registered state and owner; no combinational path from req to gnt.
//  Latency: req high in IDLE (engine ready) -> gnt/fib_start next cycle; resp_tick 1 cycle after the done_tick cycle.
//  Minimum turnaround: one IDLE cycle between DONE and the next START.
//  Boundaries:
//   - req dropped during START/WAIT/DONE: ignored, transaction completes, resp_tick still issued.
//   - req still high after its gnt: treated as a new request; rejoins arbitration at lowest priority.
//   - fib_ready low in IDLE: no grant; pending reqs wait, no reqs lost.
//   - fib_done_tick outside WAIT: ignored, e.g. stale completion after scheduler reset.
//   - fib_done_tick on first WAIT cycle: accepted.
//   - reset_n low mid-operation: immediate return to reset values; in-flight job dropped, no resp_tick.
//   - req_i changes after gnt: no effect; index latched in IDLE.
// CONFIGURATION
//  FIB_SCHED_TIMEOUT_EN defined: 16-bit WAIT counter, cleared on WAIT entry.
//   After TMO_CYCLES WAIT cycles without fib_done_tick: result_reg<=0, err_reg<=1 -> DONE.
//   Normal completion clears err_reg.
//  Undefined: no counter; WAIT waits indefinitely; err tied 0.
// TESTING (bench uses behavioural engine model: f=fib(i), done 3+i cycles after start)
//  1 req=0001, i0=10 -> gnt=0001 one cycle, fib_start with fib_i=10; resp_tick=0001, result=55, err=0.
//  2 req=1111 together, i=3,5,7,9, ptr=0 -> grants in order 0,1,2,3; results 2,5,13,34.
//  3 req0 and req2 held high continuously -> grants alternate 0,2,0,2; req1/req3 never granted.
//  4 fib_ready=0 for 20 cycles with req=0010 -> gnt stays 0; grant in the cycle after fib_ready rises.
//  5 reset_n low 2 cycles during WAIT -> outputs 0 at once; engine's later done_tick gives no resp_tick.
//  6 FIB_SCHED_TIMEOUT_EN, TMO_CYCLES=64, engine never completes ->
//    resp_tick[owner] with err=1, result=0 after 64 WAIT cycles; next request is then served normally.

Source files
------------

// File: rtl/fib_sched.sv
// fib_sched: round-robin scheduler sharing one external fib engine among NREQ requesters.
// Optional WAIT watchdog: define FIB_SCHED_TIMEOUT_EN (limit TMO_CYCLES).
module fib_sched #(
    parameter int NREQ       = 4,
    parameter int IW         = 5,
    parameter int FW         = 20,
    parameter int TMO_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IW-1:0]   req_i,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      resp_tick,
    output logic [FW-1:0]        result,
    output logic                 err,
    output logic                 busy,
    output logic                 fib_start,
    output logic [IW-1:0]        fib_i,
    input  logic                 fib_ready,
    input  logic                 fib_done_tick,
    input  logic [FW-1:0]        fib_f
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject parameter sets the arbiter and watchdog are not built for.
    if (NREQ < 2 || NREQ > 8 || IW < 1 || FW < 1 || TMO_CYCLES < 1) begin : g_bad_cfg
        $error("fib_sched: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   win;
    logic [PW:0]     pos;
    logic            found;
    logic [IW-1:0]   idx_reg;
    logic [IW-1:0]   sel_i;
    logic [FW-1:0]   result_reg;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] owner_oh;
    logic [PW-1:0]   ptr_nxt;

`ifdef FIB_SCHED_TIMEOUT_EN
    logic [15:0]     tmo_cnt;
    logic            err_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign fib_i    = idx_reg;
    assign result   = result_reg;
    assign win_oh   = NREQ'(1) << win;
    assign owner_oh = NREQ'(1) << owner;
    assign ptr_nxt  = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

    // Round-robin search: first active request starting at ptr, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        pos   = '0;
        for (int off = 0; off < NREQ; off++) begin
            pos = {1'b0, ptr} + (PW+1)'(off);
            if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
            if (!found && req[pos[PW-1:0]]) begin
                found = 1'b1;
                win   = pos[PW-1:0];
            end
        end
    end

    // Index slice of the current arbitration winner.
    always_comb begin
        sel_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == PW'(k)) sel_i = req_i[k*IW +: IW];
        end
    end

    // Scheduler FSM; every output is a register loaded on the state transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            idx_reg    <= '0;
            result_reg <= '0;
            gnt        <= '0;
            resp_tick  <= '0;
            busy       <= 1'b0;
            fib_start  <= 1'b0;
`ifdef FIB_SCHED_TIMEOUT_EN
            tmo_cnt    <= '0;
            err_reg    <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            resp_tick <= '0;
            fib_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found && fib_ready) begin
                        owner     <= win;
                        idx_reg   <= sel_i;
                        gnt       <= win_oh;
                        fib_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
`ifdef FIB_SCHED_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (fib_done_tick) begin
                        result_reg <= fib_f;
                        resp_tick  <= owner_oh;
                        state      <= DONE;
`ifdef FIB_SCHED_TIMEOUT_EN
                        err_reg    <= 1'b0;
                    end else if (tmo_cnt == 16'(TMO_CYCLES - 1)) begin
                        result_reg <= '0;
                        err_reg    <= 1'b1;
                        resp_tick  <= owner_oh;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    end
                end
                DONE: begin
                    ptr   <= ptr_nxt;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef FIB_SCHED_TIMEOUT_EN
                    err_reg <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: directed bench for fib_sched with a behavioural fib engine.
// Engine returns fib(i) 3+i cycles after start (1 cycle in fast mode).
module tb_fib_sched;

    localparam int NREQ = 4;
    localparam int IW   = 5;
    localparam int FW   = 20;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*IW-1:0]   req_i = '0;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      resp_tick;
    logic [FW-1:0]        result;
    logic                 err;
    logic                 busy;
    logic                 fib_start;
    logic [IW-1:0]        fib_i;
    logic                 fib_ready;
    logic                 fib_done_tick;
    logic [FW-1:0]        fib_f;

    int checks = 0;
    int errors = 0;

    fib_sched #(.NREQ(NREQ), .IW(IW), .FW(FW), .TMO_CYCLES(64)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_i(req_i),
        .gnt(gnt),
        .resp_tick(resp_tick),
        .result(result),
        .err(err),
        .busy(busy),
        .fib_start(fib_start),
        .fib_i(fib_i),
        .fib_ready(fib_ready),
        .fib_done_tick(fib_done_tick),
        .fib_f(fib_f)
    );

    always #5 clk = ~clk;

    // Behavioural engine.
    logic          eng_run = 1'b0;
    int            eng_cnt = 0;
    logic [IW-1:0] eng_i = '0;
    logic          force_low = 1'b0;
    logic          hang = 1'b0;
    logic          fast = 1'b0;

    function automatic logic [FW-1:0] fib(input logic [IW-1:0] n);
        logic [FW-1:0] a, b, t;
        a = '0;
        b = FW'(1);
        for (int j = 0; j < int'(n); j++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    assign fib_ready     = !eng_run && !force_low;
    assign fib_done_tick = eng_run && (eng_cnt == 1);
    assign fib_f         = fib(eng_i);

    always @(posedge clk) begin
        if (fib_start && !hang) begin
            eng_run <= 1'b1;
            eng_i   <= fib_i;
            eng_cnt <= fast ? 1 : int'(fib_i) + 3;
        end else if (eng_run) begin
            if (eng_cnt == 1) eng_run <= 1'b0;
            eng_cnt <= eng_cnt - 1;
        end
    end

    // Event log sampled on the falling edge.
    int            cyc = 0;
    int            done_cyc = 0;
    int            done_cnt = 0;
    int            gnt_cyc = 0;
    int            resp_cyc = 0;
    int            gnt_q[$];
    int            own_q[$];
    logic [FW-1:0] res_q[$];
    logic          err_q[$];

    always @(negedge clk) begin
        cyc++;
        if (fib_done_tick) begin
            done_cyc = cyc;
            done_cnt++;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_q.push_back(k);
                gnt_cyc = cyc;
            end
            if (resp_tick[k]) begin
                own_q.push_back(k);
                res_q.push_back(result);
                err_q.push_back(err);
                resp_cyc = cyc;
            end
        end
    end

    logic auto_drop = 1'b0;

    task automatic run1();
        @(posedge clk);
        @(negedge clk);
        #1;
        if (auto_drop) req = req & ~gnt;
    endtask

    task automatic set_idx(input int k, input int v);
        req_i[k*IW +: IW] = IW'(v);
    endtask

    task automatic clear_log();
        gnt_q.delete();
        own_q.delete();
        res_q.delete();
        err_q.delete();
    endtask

    task automatic do_reset();
        req       = '0;
        auto_drop = 1'b0;
        reset_n   = 1'b0;
        run1();
        run1();
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic wait_resp(input int n, input int budget);
        int b = 0;
        while (own_q.size() < n && b < budget) begin
            run1();
            b++;
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt got %b want 0000", gnt);
        end
        checks++;
        if (resp_tick !== 4'b0000) begin
            errors++; $display("FAIL reset_resp got %b want 0000", resp_tick);
        end
        checks++;
        if (busy !== 1'b0 || fib_start !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b start=%b err=%b want 0 0 0", busy, fib_start, err);
        end
        checks++;
        if (fib_i !== 5'd0 || result !== 20'd0) begin
            errors++; $display("FAIL reset_regs got i=%0d res=%0d want 0 0", fib_i, result);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_idx(0, 10);
        req = 4'b0001;
        run1();
        checks++;
        if (gnt !== 4'b0001 || fib_start !== 1'b1) begin
            errors++; $display("FAIL single_gnt got gnt=%b start=%b want 0001 1", gnt, fib_start);
        end
        checks++;
        if (fib_i !== 5'd10) begin
            errors++; $display("FAIL single_fib_i got %0d want 10", fib_i);
        end
        req = 4'b0000;
        set_idx(0, 3);
        run1();
        checks++;
        if (gnt !== 4'b0000 || fib_start !== 1'b0) begin
            errors++; $display("FAIL single_pulse got gnt=%b start=%b want 0000 0", gnt, fib_start);
        end
        checks++;
        if (fib_i !== 5'd10 || busy !== 1'b1) begin
            errors++; $display("FAIL single_hold got i=%0d busy=%b want 10 1", fib_i, busy);
        end
        wait_resp(1, 100);
        checks++;
        if (own_q.size() !== 1 || qget(own_q, 0) !== 0) begin
            errors++; $display("FAIL single_resp got n=%0d own=%0d want 1 0", own_q.size(), qget(own_q, 0));
        end
        checks++;
        if (res_q.size() < 1 || res_q[0] !== 20'd55 || err_q[0] !== 1'b0) begin
            errors++; $display("FAIL single_result got n=%0d want result 55 err 0", res_q.size());
        end
        checks++;
        if (resp_cyc !== done_cyc + 1) begin
            errors++; $display("FAIL single_latency got %0d want %0d", resp_cyc, done_cyc + 1);
        end
    endtask

    task automatic test_all_four();
        int            eg[4];
        logic [FW-1:0] er[4];
        eg = '{0, 1, 2, 3};
        er = '{20'd2, 20'd5, 20'd13, 20'd34};
        do_reset();
        set_idx(0, 3);
        set_idx(1, 5);
        set_idx(2, 7);
        set_idx(3, 9);
        auto_drop = 1'b1;
        req = 4'b1111;
        wait_resp(4, 400);
        auto_drop = 1'b0;
        checks++;
        if (own_q.size() !== 4 || gnt_q.size() !== 4) begin
            errors++; $display("FAIL all_count got %0d/%0d want 4/4", gnt_q.size(), own_q.size());
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (qget(gnt_q, j) !== eg[j] || qget(own_q, j) !== eg[j]) begin
                errors++;
                $display("FAIL all_order[%0d] got gnt=%0d own=%0d want %0d", j, qget(gnt_q, j), qget(own_q, j), eg[j]);
            end
            checks++;
            if (j >= res_q.size() || res_q[j] !== er[j]) begin
                errors++; $display("FAIL all_result[%0d] want %0d", j, er[j]);
            end
        end
    endtask

    task automatic test_hold();
        int eg[4];
        int b = 0;
        eg = '{0, 2, 0, 2};
        do_reset();
        set_idx(0, 2);
        set_idx(1, 4);
        set_idx(2, 6);
        set_idx(3, 8);
        req = 4'b0101;
        while (gnt_q.size() < 4 && b < 400) begin
            run1();
            b++;
        end
        req = 4'b0000;
        wait_resp(4, 100);
        checks++;
        if (gnt_q.size() !== 4 || own_q.size() !== 4) begin
            errors++; $display("FAIL hold_count got %0d/%0d want 4/4", gnt_q.size(), own_q.size());
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (qget(gnt_q, j) !== eg[j]) begin
                errors++; $display("FAIL hold_order[%0d] got %0d want %0d", j, qget(gnt_q, j), eg[j]);
            end
        end
    endtask

    task automatic test_ready_low();
        do_reset();
        force_low = 1'b1;
        set_idx(1, 4);
        auto_drop = 1'b1;
        req = 4'b0010;
        for (int j = 0; j < 20; j++) run1();
        checks++;
        if (gnt_q.size() !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL ready_low_gnt got n=%0d busy=%b want 0 0", gnt_q.size(), busy);
        end
        force_low = 1'b0;
        run1();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL ready_rise_gnt got %b want 0010", gnt);
        end
        wait_resp(1, 100);
        auto_drop = 1'b0;
        checks++;
        if (res_q.size() < 1 || res_q[0] !== 20'd3 || qget(own_q, 0) !== 1) begin
            errors++; $display("FAIL ready_result got n=%0d want result 3 owner 1", res_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int b = 0;
        do_reset();
        set_idx(0, 20);
        auto_drop = 1'b1;
        req = 4'b0001;
        run1();
        run1();
        run1();
        run1();
        auto_drop = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy got %b want 1", busy);
        end
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || resp_tick !== 4'b0000 || fib_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got busy=%b gnt=%b resp=%b start=%b want 0", busy, gnt, resp_tick, fib_start);
        end
        run1();
        run1();
        reset_n = 1'b1;
        clear_log();
        while (done_cnt == d0 && b < 60) begin
            run1();
            b++;
        end
        run1();
        run1();
        checks++;
        if (done_cnt == d0) begin
            errors++; $display("FAIL mid_stale_done got none want engine done_tick");
        end
        checks++;
        if (own_q.size() !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_no_resp got n=%0d busy=%b want 0 0", own_q.size(), busy);
        end
    endtask

    task automatic test_first_wait();
        do_reset();
        fast = 1'b1;
        set_idx(2, 6);
        auto_drop = 1'b1;
        req = 4'b0100;
        wait_resp(1, 50);
        auto_drop = 1'b0;
        fast = 1'b0;
        checks++;
        if (done_cyc !== gnt_cyc + 1 || resp_cyc !== gnt_cyc + 2) begin
            errors++;
            $display("FAIL first_wait_timing got done=%0d resp=%0d want %0d %0d", done_cyc, resp_cyc, gnt_cyc + 1, gnt_cyc + 2);
        end
        checks++;
        if (res_q.size() < 1 || res_q[0] !== 20'd8 || qget(own_q, 0) !== 2) begin
            errors++; $display("FAIL first_wait_result got n=%0d want result 8 owner 2", res_q.size());
        end
    endtask

`ifdef FIB_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        hang = 1'b1;
        set_idx(2, 7);
        auto_drop = 1'b1;
        req = 4'b0100;
        wait_resp(1, 200);
        hang = 1'b0;
        checks++;
        if (res_q.size() < 1 || res_q[0] !== 20'd0 || err_q[0] !== 1'b1 || qget(own_q, 0) !== 2) begin
            errors++; $display("FAIL tmo_resp got n=%0d want result 0 err 1 owner 2", res_q.size());
        end
        checks++;
        if (resp_cyc !== gnt_cyc + 65) begin
            errors++; $display("FAIL tmo_latency got %0d want %0d", resp_cyc, gnt_cyc + 65);
        end
        set_idx(3, 8);
        req = 4'b1000;
        wait_resp(2, 100);
        auto_drop = 1'b0;
        checks++;
        if (res_q.size() < 2 || res_q[1] !== 20'd21 || err_q[1] !== 1'b0 || qget(own_q, 1) !== 3) begin
            errors++; $display("FAIL tmo_recover got n=%0d want result 21 err 0 owner 3", res_q.size());
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_hold();
        test_ready_low();
        test_reset_mid();
        test_first_wait();
`ifdef FIB_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
